// File: rtl/packet_tx_if.sv
// Router ingress bundle: command and payload handshakes in,
// framed byte stream with stop backpressure out.
interface packet_tx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 6
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] cmd_dest;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  pl_valid;
    logic                  pl_ready;
    logic [DATA_WIDTH-1:0] pl_data;
    logic                  stop_packet;
    logic [DATA_WIDTH-1:0] packet_out;
    logic                  packet_valid;

    modport master (
        output cmd_valid, cmd_dest, cmd_len,
        output pl_valid, pl_data, stop_packet,
        input  cmd_ready, pl_ready,
        input  packet_out, packet_valid
    );

    modport slave (
        input  cmd_valid, cmd_dest, cmd_len,
        input  pl_valid, pl_data, stop_packet,
        output cmd_ready, pl_ready,
        output packet_out, packet_valid
    );
endinterface

// File: rtl/packet_tx.sv
// Packet source: header, length, payload, parity framing
// into the router ingress, honouring stop_packet.
module packet_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 6,
    parameter int GAP_CYCLES = 1,
    parameter int DEST_MIN   = 1,
    parameter int DEST_MAX   = 3
) (
    input  logic       clk,
    input  logic       rst,
    packet_tx_if.slave bus,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);
    localparam logic [DATA_WIDTH-1:0] DMIN = DATA_WIDTH'(DEST_MIN);
    localparam logic [DATA_WIDTH-1:0] DMAX = DATA_WIDTH'(DEST_MAX);
    localparam logic [3:0]            GAPC = 4'(GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE, HDR, LEN, PAY, PAR, GAP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] byte_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] parity;
    logic [DATA_WIDTH-1:0] dest_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [3:0]            gcnt;

    logic xfer;
    logic free;
    logic accept;
    logic cmd_ok;
    logic pl_take;

    assign xfer    = valid_q & ~bus.stop_packet;
    assign free    = ~valid_q | xfer;
    assign accept  = bus.cmd_valid & bus.cmd_ready;
    assign cmd_ok  = (bus.cmd_dest >= DMIN) &&
                     (bus.cmd_dest <= DMAX) &&
                     (bus.cmd_len != '0);
    assign pl_take = bus.pl_valid & bus.pl_ready;

    assign bus.packet_valid = valid_q & ~bus.stop_packet;
    assign bus.packet_out   = byte_q;
    assign bus.cmd_ready    = (state == IDLE);
    assign bus.pl_ready     = (state == PAY) && free;
    assign busy             = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            byte_q  <= '0;
            valid_q <= 1'b0;
            parity  <= '0;
            dest_q  <= '0;
            len_q   <= '0;
            cnt     <= '0;
            gcnt    <= '0;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            // Any load below overrides this drop of a sent byte
            if (xfer)
                valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (!cmd_ok) begin
                            tx_err <= 1'b1;
                        end else begin
                            dest_q <= bus.cmd_dest;
                            len_q  <= bus.cmd_len;
                            if (free) begin
                                byte_q  <= bus.cmd_dest;
                                valid_q <= 1'b1;
                                parity  <= bus.cmd_dest;
                                state   <= LEN;
                            end else begin
                                parity <= '0;
                                state  <= HDR;
                            end
                        end
                    end
                end
                HDR: begin
                    if (free) begin
                        byte_q  <= dest_q;
                        valid_q <= 1'b1;
                        parity  <= parity ^ dest_q;
                        state   <= LEN;
                    end
                end
                LEN: begin
                    if (free) begin
                        byte_q  <= DATA_WIDTH'(len_q);
                        valid_q <= 1'b1;
                        parity  <= parity ^ DATA_WIDTH'(len_q);
                        cnt     <= len_q;
                        state   <= PAY;
                    end
                end
                PAY: begin
                    if (pl_take) begin
                        byte_q  <= bus.pl_data;
                        valid_q <= 1'b1;
                        parity  <= parity ^ bus.pl_data;
                        cnt     <= cnt - LEN_WIDTH'(1);
                        if (cnt == LEN_WIDTH'(1))
                            state <= PAR;
                    end
                end
                PAR: begin
                    if (free) begin
                        byte_q  <= parity;
                        valid_q <= 1'b1;
                        gcnt    <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    // First idle cycle after parity is the drain cycle
                    if (valid_q) begin
                        if (xfer) begin
                            tx_done <= 1'b1;
                            if (GAPC == 4'd0)
                                state <= IDLE;
                            else
                                gcnt <= 4'd1;
                        end
                    end else if (gcnt >= GAPC) begin
                        state <= IDLE;
                    end else begin
                        gcnt <= gcnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_packet_tx.sv
// Directed bench for packet_tx: framing, stall, reject,
// payload bubbles, mid-packet reset and back-to-back packets.
module tb_packet_tx;
    logic clk;
    logic rst;
    logic busy;
    logic tx_done;
    logic tx_err;

    packet_tx_if #(.DATA_WIDTH(8), .LEN_WIDTH(6)) bus ();

    packet_tx #(
        .DATA_WIDTH(8),
        .LEN_WIDTH (6),
        .GAP_CYCLES(1),
        .DEST_MIN  (1),
        .DEST_MAX  (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy   (busy),
        .tx_done(tx_done),
        .tx_err (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    logic [7:0] q_byte[$];
    int         q_cyc[$];
    int         acc_cyc[$];
    int         n_done = 0;
    int         done_cyc = 0;
    int         n_err = 0;
    int         pl_idx = 0;
    logic [7:0] pay[$];
    logic       pl_en = 1'b0;
    logic [7:0] exp_q[$];
    logic       stall_ok;

    // Observation at the falling edge, away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (bus.packet_valid) begin
            q_byte.push_back(bus.packet_out);
            q_cyc.push_back(cyc);
        end
        if (bus.pl_valid && bus.pl_ready)
            pl_idx++;
        if (bus.cmd_valid && bus.cmd_ready)
            acc_cyc.push_back(cyc);
        if (tx_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (tx_err)
            n_err++;
    end

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_seq(string tag);
        chk({tag, "_n"}, q_byte.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i),
                32'(q_byte[i]), 32'(exp_q[i]));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        if (pl_idx < pay.size())
            bus.pl_data = pay[pl_idx];
        bus.pl_valid = pl_en && (pl_idx < pay.size());
    endtask

    task automatic clear();
        q_byte.delete();
        q_cyc.delete();
        acc_cyc.delete();
        n_done = 0;
        n_err  = 0;
        pl_idx = 0;
    endtask

    task automatic send_cmd(logic [7:0] d, logic [5:0] l);
        bus.cmd_valid = 1'b1;
        bus.cmd_dest  = d;
        bus.cmd_len   = l;
        if (pl_idx < pay.size())
            bus.pl_data = pay[pl_idx];
        bus.pl_valid = pl_en && (pl_idx < pay.size());
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(string tag, int n);
        for (int i = 0; i < 60 && !(n_done >= n && !busy); i++)
            tick();
        chk({tag, "_timeout"}, 32'(n_done >= n && !busy), 1);
    endtask

    initial begin
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_dest    = '0;
        bus.cmd_len     = '0;
        bus.pl_valid    = 1'b0;
        bus.pl_data     = '0;
        bus.stop_packet = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_pl_ready", 32'(bus.pl_ready), 0);
        chk("rst_pkt_valid", 32'(bus.packet_valid), 0);
        chk("rst_pkt_out", 32'(bus.packet_out), 0);
        chk("rst_flags", {29'd0, busy, tx_done, tx_err}, 0);
        rst = 1'b0;
        tick();

        // T1 plain packet
        clear();
        pay = '{8'hA1, 8'hB2, 8'hC3};
        pl_en = 1'b1;
        send_cmd(8'd2, 6'd3);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_cmd_ready", 32'(bus.cmd_ready), 0);
        wait_done("t1", 1);
        exp_q = '{8'h02, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hD1};
        chk_seq("t1");
        chk("t1_hdr_lat", 32'(q_cyc[0] - acc_cyc[0]), 1);
        chk("t1_span", 32'(q_cyc[5] - q_cyc[0]), 5);
        chk("t1_done_at", 32'(done_cyc - q_cyc[5]), 1);
        chk("t1_n_done", 32'(n_done), 1);

        // T2 stall while B2 is held
        clear();
        send_cmd(8'd2, 6'd3);
        for (int i = 0; i < 20 &&
             !(bus.packet_valid && bus.packet_out == 8'hB2); i++)
            tick();
        chk("t2_reach_b2", 32'(bus.packet_out), 32'h0B2);
        bus.stop_packet = 1'b1;
        stall_ok = 1'b1;
        repeat (4) begin
            tick();
            if (bus.packet_valid !== 1'b0 ||
                bus.packet_out !== 8'hB2)
                stall_ok = 1'b0;
        end
        bus.stop_packet = 1'b0;
        chk("t2_stall_hold", 32'(stall_ok), 1);
        wait_done("t2", 1);
        chk_seq("t2");
        chk("t2_n_done", 32'(n_done), 1);

        // T3 rejected commands
        clear();
        send_cmd(8'd0, 6'd3);
        chk("t3_err_d0", 32'(tx_err), 1);
        chk("t3_rdy_d0", 32'(bus.cmd_ready), 1);
        tick();
        chk("t3_err_pulse", 32'(tx_err), 0);
        send_cmd(8'd4, 6'd3);
        chk("t3_err_d4", 32'(tx_err), 1);
        send_cmd(8'd2, 6'd0);
        chk("t3_err_l0", 32'(tx_err), 1);
        chk("t3_busy", 32'(busy), 0);
        tick();
        tick();
        chk("t3_n_err", 32'(n_err), 3);
        chk("t3_no_bytes", 32'(q_byte.size()), 0);

        // T4 payload bubbles
        clear();
        pay = '{8'h11, 8'h22};
        send_cmd(8'd1, 6'd2);
        for (int i = 0; i < 20 && pl_idx < 1; i++)
            tick();
        pl_en = 1'b0;
        bus.pl_valid = 1'b0;
        repeat (3) tick();
        pl_en = 1'b1;
        bus.pl_valid = 1'b1;
        wait_done("t4", 1);
        exp_q = '{8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
        chk_seq("t4");
        chk("t4_bubble", 32'(q_cyc[3] - q_cyc[2]), 4);
        chk("t4_n_done", 32'(n_done), 1);

        // T5 reset after the length byte
        clear();
        pay = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        send_cmd(8'd3, 6'd5);
        for (int i = 0; i < 20 && q_byte.size() < 2; i++)
            tick();
        chk("t5_len_seen", 32'(q_byte[1]), 32'h05);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(bus.packet_valid), 0);
        chk("t5_rst_out", 32'(bus.packet_out), 0);
        chk("t5_rst_flags",
            {28'd0, busy, bus.pl_ready, tx_done, tx_err}, 0);
        chk("t5_rst_ready", 32'(bus.cmd_ready), 1);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("t5_no_done", 32'(n_done), 0);
        clear();
        pay = '{8'h5A};
        send_cmd(8'd1, 6'd1);
        wait_done("t5", 1);
        exp_q = '{8'h01, 8'h01, 8'h5A, 8'h5A};
        chk_seq("t5");

        // T6 back-to-back commands
        clear();
        pay = '{8'hAA, 8'hBB};
        send_cmd(8'd1, 6'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_dest  = 8'd2;
        bus.cmd_len   = 6'd1;
        for (int i = 0; i < 30 && acc_cyc.size() < 2; i++)
            tick();
        bus.cmd_valid = 1'b0;
        wait_done("t6", 2);
        exp_q = '{8'h01, 8'h01, 8'hAA, 8'hAA,
                  8'h02, 8'h01, 8'hBB, 8'hB8};
        chk_seq("t6");
        chk("t6_acc2", 32'(acc_cyc[1] - q_cyc[3]), 2);
        chk("t6_hdr2", 32'(q_cyc[4] - q_cyc[3]), 3);
        chk("t6_n_done", 32'(n_done), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
